// File: rtl/ram_pkg.sv
// Shared definitions for the RAM stream reader: FSM states, default geometry
// and the address-derived pattern that the write-side generator stores.
package ram_pkg;

    localparam int RAM_AW = 4;
    localparam int RAM_DW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The writer fills each location with the inverted address; callers truncate to DW.
    function automatic logic [31:0] expected_pattern(input logic [31:0] addr);
        return ~addr;
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready stream carrying words read back from the RAM.
interface ram_stream_reader_if #(
    parameter int DW = 4
) ();
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ram_stream_skid.sv
// Two-entry synchronous FIFO that absorbs RAM read data while downstream stalls.
module ram_stream_skid #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count
);

    logic [DW-1:0] entry_reg [2];
    logic [1:0]    wr_en;
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic          pop_ok;

    assign pop_ok = pop && (count_reg != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i]) begin
                    entry_reg[i] <= push_data;
                end
            end
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign head_data = entry_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a RAM address range and streams the words out with backpressure.
// Optional pattern checking against ~address is enabled by RAM_READER_VERIFY_EN.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       start_addr,
    input  logic [AW:0]         length,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       ram_address,
    input  logic [DW-1:0]       ram_q,
    ram_stream_reader_if.master stream,
    output logic [AW:0]         mismatch_count
);

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [AW:0]   remaining_reg, remaining_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          inflight_reg;
    logic          issue;
    logic          start_accept;
    logic          pop;
    logic          credit_ok;
    logic [1:0]    skid_count;
    logic [DW-1:0] head_data;

    ram_stream_skid #(.DW(DW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data (ram_q),
        .pop       (pop),
        .head_data (head_data),
        .count     (skid_count)
    );

    assign stream.out_valid = (skid_count != 2'd0);
    assign stream.out_data  = head_data;
    assign pop              = stream.out_valid && stream.out_ready;

    // A word popped this cycle frees its slot in time for the read issued now,
    // which keeps the stream bubble-free with only two buffer entries.
    assign credit_ok = (3'(skid_count) + 3'(inflight_reg)) < (3'd2 + 3'(pop));

    // The cycle done is high the FSM is already idle, so start must be masked there.
    assign start_accept = (state_reg == ST_IDLE) && start && !done_reg;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        issue          = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_accept) begin
                    if (length == '0) begin
                        state_next = ST_DRAIN;
                    end else begin
                        addr_next      = start_addr;
                        remaining_next = length;
                        busy_next      = 1'b1;
                        state_next     = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue          = 1'b1;
                    addr_next      = addr_reg + AW'(1);
                    remaining_next = remaining_reg - (AW+1)'(1);
                    if (remaining_reg == (AW+1)'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_reg && (skid_count == 2'd0)) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            inflight_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            inflight_reg  <= issue;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign ram_address = addr_reg;

`ifdef RAM_READER_VERIFY_EN
    logic [AW-1:0] inflight_addr_reg;
    logic [AW:0]   mismatch_reg;
    logic          word_bad;

    assign word_bad = inflight_reg &&
                      (ram_q != DW'(expected_pattern(32'(inflight_addr_reg))));

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_addr_reg <= '0;
            mismatch_reg      <= '0;
        end else begin
            if (issue) begin
                inflight_addr_reg <= addr_reg;
            end
            if (start_accept) begin
                mismatch_reg <= '0;
            end else if (word_bad && (mismatch_reg != '1)) begin
                mismatch_reg <= mismatch_reg + (AW+1)'(1);
            end
        end
    end

    assign mismatch_count = mismatch_reg;
`else
    assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 16x4 registered-q RAM.
module tb_ram_stream_reader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic [3:0] ram_address;
    logic [3:0] ram_q;
    logic [4:0] mismatch_count;

    logic [3:0] mem [16];

    int n_compared   = 0;
    int n_mismatched = 0;
    int done_cnt     = 0;
    int stall_err    = 0;
    logic [3:0] beats [$];
    logic       stalled_prev = 1'b0;
    logic [3:0] stalled_data = 4'h0;
    bit         rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    ram_stream_reader_if #(.DW(4)) stream_if ();

    ram_stream_reader #(.AW(4), .DW(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .ram_address    (ram_address),
        .ram_q          (ram_q),
        .stream         (stream_if.master),
        .mismatch_count (mismatch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        ram_q <= mem[ram_address];
    end

    always @(posedge clk) begin
        if (stalled_prev && (!stream_if.out_valid || (stream_if.out_data != stalled_data))) begin
            stall_err <= stall_err + 1;
        end
        if (stream_if.out_valid && stream_if.out_ready) begin
            beats.push_back(stream_if.out_data);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
        stalled_prev <= stream_if.out_valid && !stream_if.out_ready;
        stalled_data <= stream_if.out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [3:0] sa, input logic [4:0] len);
        start_addr = sa;
        length     = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit toggle);
        int c = 0;
        while (!done && (c < budget)) begin
            if (toggle) stream_if.out_ready = rdy_pat[c % 4];
            tick();
            c++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic check_beats(input string tag, input logic [3:0] first_exp, input int n);
        check({tag, "_beat_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(4'(first_exp - 4'(i))));
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        done_cnt = 0;
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            mem[a] = ~4'(a);
        end
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = 4'h0;
        length     = 5'd0;
        stream_if.out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(stream_if.out_valid), 32'd0);
        check("rst_data", 32'(stream_if.out_data), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_mismatch", 32'(mismatch_count), 32'd0);
        reset = 1'b0;
        tick();

        // Full sweep: first valid two edges after start, then F..0 back to back.
        clear_mon();
        run_cmd(4'd0, 5'd16);
        check("sweep_busy_e0", 32'(busy), 32'd1);
        check("sweep_valid_e0", 32'(stream_if.out_valid), 32'd0);
        tick();
        check("sweep_valid_e1", 32'(stream_if.out_valid), 32'd0);
        tick();
        check("sweep_valid_e2", 32'(stream_if.out_valid), 32'd1);
        check("sweep_data_e2", 32'(stream_if.out_data), 32'hF);
        wait_done("sweep", 40, 1'b0);
        check("sweep_busy_at_done", 32'(busy), 32'd0);
        check_beats("sweep", 4'hF, 16);
        tick();
        tick();
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        check("sweep_done_low", 32'(done), 32'd0);
`ifndef RAM_READER_VERIFY_EN
        check("sweep_mismatch_tied", 32'(mismatch_count), 32'd0);
`endif

        // Wrap from 14: addresses 14,15,0,1 give 1,0,F,E.
        clear_mon();
        run_cmd(4'd14, 5'd4);
        check("wrap_addr0", 32'(ram_address), 32'd14);
        tick();
        check("wrap_addr1", 32'(ram_address), 32'd15);
        tick();
        check("wrap_addr2", 32'(ram_address), 32'd0);
        tick();
        check("wrap_addr3", 32'(ram_address), 32'd1);
        wait_done("wrap", 20, 1'b0);
        check_beats("wrap", 4'h1, 4);

        // Zero length, plus a start presented while done is high.
        tick();
        clear_mon();
        run_cmd(4'd3, 5'd0);
        check("zero_busy_e0", 32'(busy), 32'd0);
        check("zero_done_e0", 32'(done), 32'd0);
        start_addr = 4'd3;
        length     = 5'd2;
        start      = 1'b1;
        #0;
        tick();
        check("zero_done_e1", 32'(done), 32'd1);
        check("zero_busy_e1", 32'(busy), 32'd0);
        start = 1'b0;
        check("zero_valid_e1", 32'(stream_if.out_valid), 32'd0);
        tick();
        check("zero_start_ignored", 32'(busy), 32'd0);
        tick();
        check("zero_still_idle", 32'(busy), 32'd0);
        check("zero_no_beats", 32'(beats.size()), 32'd0);
        check("zero_done_pulses", 32'(done_cnt), 32'd1);

        // Backpressure: ready follows 1,0,0,1 and the stream must not lose or repeat.
        clear_mon();
        stall_err = 0;
        stream_if.out_ready = rdy_pat[0];
        run_cmd(4'd0, 5'd8);
        wait_done("bp", 80, 1'b1);
        check_beats("bp", 4'hF, 8);
        check("bp_stall_stable", 32'(stall_err), 32'd0);
        stream_if.out_ready = 1'b1;
        tick();
        tick();
        check("bp_done_pulses", 32'(done_cnt), 32'd1);

        // Reset after the third accepted beat, then a fresh command from 4.
        clear_mon();
        run_cmd(4'd0, 5'd16);
        for (int c = 0; c < 20 && beats.size() < 3; c++) begin
            tick();
        end
        check("rstop_reached_beat3", 32'(beats.size() >= 3), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstop_valid", 32'(stream_if.out_valid), 32'd0);
        check("rstop_busy", 32'(busy), 32'd0);
        check("rstop_done", 32'(done), 32'd0);
        tick();
        clear_mon();
        run_cmd(4'd4, 5'd3);
        wait_done("rstop_new", 20, 1'b0);
        check_beats("rstop_new", 4'hB, 3);

`ifdef RAM_READER_VERIFY_EN
        // One corrupted location is counted once; the next start clears the count.
        tick();
        mem[5] = 4'h0;
        clear_mon();
        run_cmd(4'd0, 5'd16);
        wait_done("verify", 40, 1'b0);
        check("verify_mismatch_one", 32'(mismatch_count), 32'd1);
        mem[5] = ~4'd5;
        tick();
        run_cmd(4'd0, 5'd1);
        check("verify_mismatch_cleared", 32'(mismatch_count), 32'd0);
        wait_done("verify_clean", 20, 1'b0);
        check("verify_clean_count", 32'(mismatch_count), 32'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
